// File: rtl/dac_spi_if.sv
// Parallel sample handshake plus serial DAC pins for dac_spi_tx.
// The master side supplies samples; the slave side drives the DAC.
interface dac_spi_if;
   logic [11:0] data_in;
   logic        data_valid;
   logic        ready;
   logic        busy;
   logic        done;
   logic        CS;
   logic        SCLK;
   logic        DIN;

   modport master (
      output data_in, data_valid,
      input  ready, busy, done, CS, SCLK, DIN
   );

   modport slave (
      input  data_in, data_valid,
      output ready, busy, done, CS, SCLK, DIN
   );
endinterface

// File: rtl/dac_spi_tx.sv
// 16-bit {CMD, data} SPI frame transmitter for a 12-bit DAC.
// Samples pass through a one-word holding buffer; every pin is registered.
module dac_spi_tx #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned GAP_CYCLES = 4,
   parameter logic [3:0]  CMD        = 4'b0011
) (
   input logic      clk,
   input logic      rst,
   dac_spi_if.slave bus
);
   localparam int unsigned CW = $clog2(CLK_DIV + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [GW-1:0] r_gcnt, w_gcnt_nxt;
   logic [4:0]    r_bit, w_bit_nxt;
   logic          r_hi, w_hi_nxt;
   logic [15:0]   r_sh, w_sh_nxt;
   logic [11:0]   r_buf;
   logic          r_full, w_full_nxt;
   logic          r_ready, r_busy, r_done;
   logic          r_cs, r_sclk, r_din;
   logic          w_load, w_done_nxt, w_accept, w_half_end;
   logic          w_frame, w_cs_d, w_sclk_d, w_din_d;

   assign w_accept   = bus.data_valid && r_ready;
   assign w_half_end = (r_cnt == HALF_END);
   // The load wins over a new write; ready is already low while full.
   assign w_full_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_full);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_gcnt  <= '0;
         r_bit   <= '0;
         r_hi    <= 1'b0;
         r_sh    <= '0;
         r_buf   <= '0;
         r_full  <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cs    <= 1'b1;
         r_sclk  <= 1'b0;
         r_din   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gcnt  <= w_gcnt_nxt;
         r_bit   <= w_bit_nxt;
         r_hi    <= w_hi_nxt;
         r_sh    <= w_sh_nxt;
         r_full  <= w_full_nxt;
         r_ready <= !w_full_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
         r_cs    <= w_cs_d;
         r_sclk  <= w_sclk_d;
         r_din   <= w_din_d;
         if (w_accept)
            r_buf <= bus.data_in;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gcnt_nxt  = r_gcnt;
      w_bit_nxt   = r_bit;
      w_hi_nxt    = r_hi;
      w_sh_nxt    = r_sh;
      w_load      = 1'b0;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_full) begin
               w_load      = 1'b1;
               w_sh_nxt    = {CMD, r_buf};
               w_cnt_nxt   = '0;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (w_half_end) begin
               w_cnt_nxt   = '0;
               w_hi_nxt    = 1'b1;
               w_bit_nxt   = '0;
               w_state_nxt = S_SHIFT;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_SHIFT: begin
            if (!w_half_end) begin
               w_cnt_nxt = r_cnt + CW'(1);
            end else begin
               w_cnt_nxt = '0;
               if (!r_hi) begin
                  w_hi_nxt = 1'b1;
               end else if (r_bit == 5'd15) begin
                  w_hi_nxt    = 1'b0;
                  w_state_nxt = S_HOLD;
               end else begin
                  // Falling edge: present the next bit for the next rise.
                  w_hi_nxt  = 1'b0;
                  w_bit_nxt = r_bit + 5'd1;
                  w_sh_nxt  = {r_sh[14:0], 1'b0};
               end
            end
         end
         S_HOLD: begin
            if (w_half_end) begin
               w_gcnt_nxt  = '0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_GAP;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_GAP: begin
            if (r_gcnt == GAP_END)
               w_state_nxt = S_IDLE;
            else
               w_gcnt_nxt = r_gcnt + GW'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pin values follow the state being entered, so they register in step.
   always_comb begin
      w_frame  = (w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT)
              || (w_state_nxt == S_HOLD);
      w_cs_d   = !w_frame;
      w_sclk_d = (w_state_nxt == S_SHIFT) && w_hi_nxt;
      w_din_d  = w_frame && w_sh_nxt[15];
   end

   assign bus.ready = r_ready;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.CS    = r_cs;
   assign bus.SCLK  = r_sclk;
   assign bus.DIN   = r_din;
endmodule
